i2c_slave_rx_ctrl: RTL

Sequencer for the I2C_read bit receiver in slave-receiver mode. It detects a frame start, enables I2C_read for whole bytes and assembles the bits into bytes. It checks the 7-bit address, drives ACK/NACK through the I2C_write bit transmitter, and hands received data bytes to the user logic through a one-entry valid/ready buffer. It sits between the SCL/SDA bit layer (I2C_read, I2C_write) and the register/FIFO side of the slave.

---
 rtl/i2c_pkg.sv | 25 ++
 rtl/i2c_slave_rx_ctrl_if.sv | 43 ++++
 rtl/i2c_rx_buf.sv | 35 +++
 rtl/i2c_slave_rx_ctrl.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding, ACK/NACK levels, address width
// and an address-match helper used by the slave receive sequencer.
package i2c_pkg;

   localparam int   I2C_ADDR_W = 7;
   localparam logic I2C_ACK    = 1'b0;
   localparam logic I2C_NACK   = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_DATA,
      ST_DATA_ACK,
      ST_WAIT_STOP
   } i2c_state_e;

   // Address byte matches when the upper seven bits equal the slave address and
   // the direction bit requests a write (slave receives).
   function automatic logic addr_match(input logic [7:0] addr_byte,
                                       input logic [I2C_ADDR_W-1:0] slave_addr);
      return (addr_byte[7:1] == slave_addr) && (addr_byte[0] == 1'b0);
   endfunction

endpackage

// File: rtl/i2c_slave_rx_ctrl_if.sv
// Bundle of the bit-layer (I2C_read / I2C_write) signals, bus events and the
// user-side receive handshake seen by the slave receive sequencer.
interface i2c_slave_rx_ctrl_if;

   // bit receiver
   logic       rd_en;
   logic       is_byte;
   logic       rd_ld;
   logic       data_o;
   logic       rd_finish;
   // bus events
   logic       get_start;
   logic       get_stop;
   logic       bus_err;
   // bit transmitter (ACK slot)
   logic       wr_en;
   logic       wr_bit;
   logic       wr_finish;
   // user side
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   // status pulses
   logic       addr_hit;
   logic       frame_end;
   logic       ovf_err;
   logic       err;

   modport slave (
      output rd_en, is_byte, wr_en, wr_bit, rx_data, rx_valid,
             addr_hit, frame_end, ovf_err, err,
      input  rd_ld, data_o, rd_finish, get_start, get_stop, bus_err,
             wr_finish, rx_ready
   );

   modport master (
      input  rd_en, is_byte, wr_en, wr_bit, rx_data, rx_valid,
             addr_hit, frame_end, ovf_err, err,
      output rd_ld, data_o, rd_finish, get_start, get_stop, bus_err,
             wr_finish, rx_ready
   );

endinterface

// File: rtl/i2c_rx_buf.sv
// One-entry valid/ready holding register. A load overwrites the entry and
// sets valid; an accept (valid & ready) without a load empties it. Loading in
// the same cycle as an accept keeps valid high with the new byte.
module i2c_rx_buf #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic [W-1:0] din_i,
   input  logic         accept_i,
   output logic         valid_o,
   output logic [W-1:0] data_o
);

   logic         valid_q;
   logic [W-1:0] data_q;

   // Entry register: load has priority over the consumer draining it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else if (load_i) begin
         valid_q <= 1'b1;
         data_q  <= din_i;
      end else if (valid_q && accept_i) begin
         valid_q <= 1'b0;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/i2c_slave_rx_ctrl.sv
// Slave-receiver sequencer: frames bytes from I2C_read, checks the address,
// drives ACK/NACK slots through I2C_write and hands data bytes to the user
// through a one-entry buffer that lives independently of the FSM.
module i2c_slave_rx_ctrl
   import i2c_pkg::*;
#(
   parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR = 7'h50
) (
   input logic               clk,
   input logic               rst_n,
   i2c_slave_rx_ctrl_if.slave bus
);

   i2c_state_e state_q, state_d;
   logic [7:0] sh_q, sh_d;
   logic       ack_q, ack_d;          // ACK level chosen for the pending data slot
   logic       gap_q, gap_d;          // forces one idle cycle between bit-layer enables
   logic       hit_q, hit_d;          // address matched since the last START
   logic       addr_hit_q, addr_hit_d;
   logic       frame_end_q, frame_end_d;
   logic       ovf_q, ovf_d;
   logic       err_q, err_d;

   logic [7:0] sh_in;
   logic       rd_en_w;
   logic       wr_en_w;
   logic       buf_load;
   logic       buf_valid;
   logic [7:0] buf_data;
   logic       buf_can_load;

   // The bit strobed together with rd_finish must be part of the byte.
   assign sh_in        = bus.rd_ld ? {sh_q[6:0], bus.data_o} : sh_q;
   assign rd_en_w      = ((state_q == ST_ADDR) || (state_q == ST_DATA)) && !gap_q;
   assign wr_en_w      = ((state_q == ST_ADDR_ACK) || (state_q == ST_DATA_ACK)) && !gap_q;
   assign buf_can_load = !buf_valid || bus.rx_ready;

   // State and status registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         sh_q        <= 8'h00;
         ack_q       <= I2C_NACK;
         gap_q       <= 1'b0;
         hit_q       <= 1'b0;
         addr_hit_q  <= 1'b0;
         frame_end_q <= 1'b0;
         ovf_q       <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         sh_q        <= sh_d;
         ack_q       <= ack_d;
         gap_q       <= gap_d;
         hit_q       <= hit_d;
         addr_hit_q  <= addr_hit_d;
         frame_end_q <= frame_end_d;
         ovf_q       <= ovf_d;
         err_q       <= err_d;
      end
   end

   // Next-state logic with event priority bus_err > STOP > START > finish.
   always_comb begin
      state_d     = state_q;
      sh_d        = sh_q;
      ack_d       = ack_q;
      gap_d       = 1'b0;
      hit_d       = hit_q;
      addr_hit_d  = 1'b0;
      frame_end_d = 1'b0;
      ovf_d       = 1'b0;
      err_d       = 1'b0;
      buf_load    = 1'b0;

      if (bus.bus_err) begin
         state_d = ST_IDLE;
         err_d   = (state_q != ST_IDLE);
         hit_d   = 1'b0;
      end else if (bus.get_stop) begin
         if (state_q != ST_IDLE) begin
            state_d     = ST_IDLE;
            frame_end_d = hit_q;
         end
         hit_d = 1'b0;
      end else if (bus.get_start) begin
         state_d = ST_ADDR;
         sh_d    = 8'h00;
         hit_d   = 1'b0;
      end else begin
         if (rd_en_w) begin
            sh_d = sh_in;
         end
         case (state_q)
            ST_ADDR: begin
               if (rd_en_w && bus.rd_finish) begin
                  gap_d = 1'b1;
                  if (addr_match(sh_in, SLAVE_ADDR)) begin
                     addr_hit_d = 1'b1;
                     hit_d      = 1'b1;
                     state_d    = ST_ADDR_ACK;
                  end else begin
                     state_d = ST_WAIT_STOP;
                  end
               end
            end
            ST_ADDR_ACK: begin
               if (wr_en_w && bus.wr_finish) begin
                  gap_d   = 1'b1;
                  state_d = ST_DATA;
               end
            end
            ST_DATA: begin
               if (rd_en_w && bus.rd_finish) begin
                  gap_d   = 1'b1;
                  state_d = ST_DATA_ACK;
                  if (buf_can_load) begin
                     buf_load = 1'b1;
                     ack_d    = I2C_ACK;
                  end else begin
                     ovf_d = 1'b1;
                     ack_d = I2C_NACK;
                  end
               end
            end
            ST_DATA_ACK: begin
               if (wr_en_w && bus.wr_finish) begin
                  gap_d   = 1'b1;
                  state_d = (ack_q == I2C_ACK) ? ST_DATA : ST_WAIT_STOP;
               end
            end
            default: ;
         endcase
      end
   end

   i2c_rx_buf #(.W(8)) u_rx_buf (
      .clk      (clk),
      .rst_n    (rst_n),
      .load_i   (buf_load),
      .din_i    (sh_in),
      .accept_i (bus.rx_ready),
      .valid_o  (buf_valid),
      .data_o   (buf_data)
   );

   assign bus.rd_en     = rd_en_w;
   assign bus.is_byte   = rd_en_w;
   assign bus.wr_en     = wr_en_w;
   assign bus.wr_bit    = (state_q == ST_ADDR_ACK) ? I2C_ACK :
                          (state_q == ST_DATA_ACK) ? ack_q   : I2C_NACK;
   assign bus.rx_valid  = buf_valid;
   assign bus.rx_data   = buf_data;
   assign bus.addr_hit  = addr_hit_q;
   assign bus.frame_end = frame_end_q;
   assign bus.ovf_err   = ovf_q;
   assign bus.err       = err_q;

endmodule
